// File: rtl/led_pattern_driver.sv
// LED pin driver for the vending-machine LED state machine: static codes go straight to the
// active-low pins, and flow codes run a timed single or bounce animation.
module led_pattern_driver #(
    parameter int STEP_CYCLES = 25_000_000,  // clocks per flow position, >= 2
    parameter int FLOW_STEPS  = 20           // positions per flow run, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] led_code,
    output logic [3:0] led,
    output logic       flow_busy,
    output logic       flow_done
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam int IDX_W = $clog2(FLOW_STEPS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FLOW_STEPS - 1);
    localparam logic [5:0]       CODE_SINGLE = 6'b01_0000;
    localparam logic [5:0]       CODE_BOUNCE = 6'b10_0000;
    localparam logic [5:0]       CODE_RESET  = 6'b00_1111;
    localparam logic [3:0]       LED_OFF     = 4'b1111;
    localparam logic [3:0]       LED_FIRST   = 4'b1110;

    typedef enum logic [1:0] {
        ST_STATIC,
        ST_SINGLE,
        ST_BOUNCE,
        ST_HOLD
    } state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    state_e           state_q, state_d;
    dir_e             dir_q,   dir_d;
    logic [5:0]       code_q,  code_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [1:0]       pos_q,   pos_d;
    logic [3:0]       led_q,   led_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (led_code != code_q) begin
            // A code change always wins, even over the final step of a running flow.
            code_d = led_code;
            cnt_d  = '0;
            idx_d  = '0;
            pos_d  = 2'd0;
            dir_d  = DIR_UP;
            if (led_code[5:4] == 2'b00) begin
                state_d = ST_STATIC;
                led_d   = led_code[3:0];
                busy_d  = 1'b0;
            end else if (led_code == CODE_SINGLE) begin
                state_d = ST_SINGLE;
                led_d   = LED_FIRST;
                busy_d  = 1'b1;
            end else if (led_code == CODE_BOUNCE) begin
                state_d = ST_BOUNCE;
                led_d   = LED_FIRST;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_STATIC;
                led_d   = LED_OFF;
                busy_d  = 1'b0;
            end
        end else if (state_q == ST_SINGLE || state_q == ST_BOUNCE) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_HOLD;
                    led_d   = LED_OFF;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (state_q == ST_SINGLE) begin
                        pos_d = pos_q + 2'd1;
                    end else if (dir_q == DIR_UP) begin
                        if (pos_q == 2'd3) begin
                            pos_d = 2'd2;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + 2'd1;
                        end
                    end else begin
                        if (pos_q == 2'd0) begin
                            pos_d = 2'd1;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - 2'd1;
                        end
                    end
                    led_d = ~(4'b0001 << pos_d);
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STATIC;
            dir_q   <= DIR_UP;
            code_q  <= CODE_RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            pos_q   <= 2'd0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led       = led_q;
    assign flow_busy = busy_q;
    assign flow_done = done_q;

endmodule
